// File: rtl/count_checker.sv
// Sequence checker for a free-running N-bit counter: locks after LOCK_CNT in-order samples,
// flags mismatches while locked. Optional err_sticky output via COUNT_CHECKER_STICKY_EN.
module count_checker #(
  parameter int N        = 5,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [N-1:0]     din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count
`ifdef COUNT_CHECKER_STICKY_EN
  ,
  output logic             err_sticky
`endif
);

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_expected, w_expected_nxt;
  logic [3:0]       r_run, w_run_nxt;
  logic [3:0]       r_miss, w_miss_nxt;
  logic             r_err, w_err_nxt;
  logic [ERR_W-1:0] r_err_count, w_err_count_nxt, w_cnt_base;
  logic             w_match;
  logic [3:0]       w_run_inc, w_miss_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SEARCH;
      r_expected  <= '0;
      r_run       <= '0;
      r_miss      <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_expected  <= w_expected_nxt;
      r_run       <= w_run_nxt;
      r_miss      <= w_miss_nxt;
      r_err       <= w_err_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_run_nxt      = r_run;
    w_miss_nxt     = r_miss;
    w_err_nxt      = 1'b0;
    w_match        = (din == r_expected);
    w_run_inc      = r_run + 4'd1;
    w_miss_inc     = r_miss + 4'd1;

    if (din_valid) begin
      w_expected_nxt = din + N'(1);
      case (r_state)
        SEARCH: begin
          w_state_nxt = LOCKING;
          w_run_nxt   = 4'd1;
        end
        LOCKING: begin
          if (w_match) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == 4'(LOCK_CNT)) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_run_nxt = 4'd1;
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            w_err_nxt = 1'b1;
            if (w_miss_inc == 4'(LOSS_CNT)) begin
              w_state_nxt = SEARCH;
              w_run_nxt   = '0;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = w_miss_inc;
            end
          end
        end
        default: begin
          w_state_nxt = SEARCH;
          w_run_nxt   = '0;
          w_miss_nxt  = '0;
        end
      endcase
    end

    // clr zeroes the base first so a coincident error still lands as a count of 1
    w_cnt_base = clr ? '0 : r_err_count;
    if (w_err_nxt && (w_cnt_base != '1))
      w_err_count_nxt = w_cnt_base + ERR_W'(1);
    else
      w_err_count_nxt = w_cnt_base;
  end

  assign locked    = (r_state == LOCKED);
  assign err       = r_err;
  assign err_count = r_err_count;

`ifdef COUNT_CHECKER_STICKY_EN
  logic r_err_sticky;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err_sticky <= 1'b0;
    else
      r_err_sticky <= w_err_nxt | (r_err_sticky & ~clr);
  end

  assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_count_checker.sv
// Directed table-driven bench for count_checker, plus hand sequences for async reset
// and err_count saturation on a narrow second instance.
module tb_count_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid, clr;
  logic [4:0]  din;
  logic        locked, err;
  logic [15:0] err_count;
  logic        sticky_obs;

  logic        s_valid, s_clr;
  logic [4:0]  s_din;
  logic        s_locked, s_err;
  logic [1:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  count_checker #(.N(5), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr(clr),
    .locked(locked), .err(err), .err_count(err_count)
`ifdef COUNT_CHECKER_STICKY_EN
    , .err_sticky(sticky_obs)
`endif
  );

`ifdef COUNT_CHECKER_STICKY_EN
  logic s_sticky;
`else
  assign sticky_obs = 1'b0;
`endif

  count_checker #(.N(5), .LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .din_valid(s_valid), .din(s_din), .clr(s_clr),
    .locked(s_locked), .err(s_err), .err_count(s_count)
`ifdef COUNT_CHECKER_STICKY_EN
    , .err_sticky(s_sticky)
`endif
  );

  typedef struct {
    logic        v;
    logic [4:0]  d;
    logic        c;
    logic        l;
    logic        e;
    logic [15:0] n;
    logic        s;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input logic [4:0] d, input logic c,
                     input logic l, input logic e, input logic [15:0] n, input logic s);
    vec_t t;
    t.v = v; t.d = d; t.c = c; t.l = l; t.e = e; t.n = n; t.s = s;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    din_valid = t.v;
    din       = t.d;
    clr       = t.c;
    @(posedge clk);
    #1;
    chk({tag, " locked"}, 16'(locked), 16'(t.l));
    chk({tag, " err"}, 16'(err), 16'(t.e));
    chk({tag, " err_count"}, err_count, t.n);
`ifdef COUNT_CHECKER_STICKY_EN
    chk({tag, " err_sticky"}, 16'(sticky_obs), 16'(t.s));
`endif
  endtask

  task automatic s_step(input logic v, input logic [4:0] d,
                        input logic l, input logic e, input logic [1:0] n, input string tag);
    @(negedge clk);
    s_valid = v;
    s_din   = d;
    @(posedge clk);
    #1;
    chk({tag, " locked"}, 16'(s_locked), 16'(l));
    chk({tag, " err"}, 16'(s_err), 16'(e));
    chk({tag, " err_count"}, 16'(s_count), 16'(n));
  endtask

  initial begin
    vec_t t;
    rst = 1'b0; din_valid = 1'b0; din = '0; clr = 1'b0;
    s_valid = 1'b0; s_din = '0; s_clr = 1'b0;

    // lock on 7..10
    add(1, 7, 0, 0, 0, 0, 0);
    add(1, 8, 0, 0, 0, 0, 0);
    add(1, 9, 0, 0, 0, 0, 0);
    add(1, 10, 0, 1, 0, 0, 0);
    // single error 12,13,20,21
    add(1, 11, 0, 1, 0, 0, 0);
    add(1, 12, 0, 1, 0, 0, 0);
    add(1, 13, 0, 1, 0, 0, 0);
    add(1, 20, 0, 1, 1, 1, 1);
    add(1, 21, 0, 1, 0, 1, 1);
    for (int k = 22; k <= 29; k++) add(1, 5'(k), 0, 1, 0, 1, 1);
    // wrap 30,31,0,1
    add(1, 30, 0, 1, 0, 1, 1);
    add(1, 31, 0, 1, 0, 1, 1);
    add(1, 0, 0, 1, 0, 1, 1);
    add(1, 1, 0, 1, 0, 1, 1);
    // valid gaps with junk data
    add(1, 2, 0, 1, 0, 1, 1);
    add(0, 9, 0, 1, 0, 1, 1);
    add(1, 3, 0, 1, 0, 1, 1);
    add(0, 0, 0, 1, 0, 1, 1);
    add(1, 4, 0, 1, 0, 1, 1);
    // clr alone keeps lock
    add(0, 0, 1, 1, 0, 0, 0);
    // loss after three mismatches
    add(1, 3, 0, 1, 1, 1, 1);
    add(1, 9, 0, 1, 1, 2, 1);
    add(1, 17, 0, 0, 1, 3, 1);
    add(0, 0, 0, 0, 0, 3, 1);
    // relock 18..21
    add(1, 18, 0, 0, 0, 3, 1);
    add(1, 19, 0, 0, 0, 3, 1);
    add(1, 20, 0, 0, 0, 3, 1);
    add(1, 21, 0, 1, 0, 3, 1);
    // clr coincident with mismatch
    add(1, 5, 1, 1, 1, 1, 1);
    add(1, 6, 0, 1, 0, 1, 1);
    add(0, 0, 1, 1, 0, 0, 0);
    // alternating mismatch/match: count to 5 without losing lock
    add(1, 0, 0, 1, 1, 1, 1);
    add(1, 1, 0, 1, 0, 1, 1);
    add(1, 0, 0, 1, 1, 2, 1);
    add(1, 1, 0, 1, 0, 2, 1);
    add(1, 0, 0, 1, 1, 3, 1);
    add(1, 1, 0, 1, 0, 3, 1);
    add(1, 0, 0, 1, 1, 4, 1);
    add(1, 1, 0, 1, 0, 4, 1);
    add(1, 0, 0, 1, 1, 5, 1);

    #12;
    chk("reset locked", 16'(locked), 16'd0);
    chk("reset err", 16'(err), 16'd0);
    chk("reset err_count", err_count, 16'd0);
    chk("reset sat err_count", 16'(s_count), 16'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

    // async reset between edges while locked, err high, count 5
    #2;
    rst = 1'b0;
    #1;
    chk("async locked", 16'(locked), 16'd0);
    chk("async err", 16'(err), 16'd0);
    chk("async err_count", err_count, 16'd0);
`ifdef COUNT_CHECKER_STICKY_EN
    chk("async err_sticky", 16'(sticky_obs), 16'd0);
`endif
    @(negedge clk);
    din_valid = 1'b0; clr = 1'b0;
    rst = 1'b1;
    t = '{v:1, d:10, c:0, l:0, e:0, n:0, s:0}; apply(t, "relock0");
    t.d = 11; apply(t, "relock1");
    t.d = 12; apply(t, "relock2");
    t.d = 13; t.l = 1; apply(t, "relock3");

    // saturation on 2-bit counter, loss threshold not reached
    s_step(1, 0, 0, 0, 0, "sat lock0");
    s_step(1, 1, 0, 0, 0, "sat lock1");
    s_step(1, 2, 0, 0, 0, "sat lock2");
    s_step(1, 3, 1, 0, 0, "sat lock3");
    s_step(1, 0, 1, 1, 1, "sat err1");
    s_step(1, 0, 1, 1, 2, "sat err2");
    s_step(1, 0, 1, 1, 3, "sat err3");
    s_step(1, 0, 1, 1, 3, "sat err4");
    s_step(1, 0, 1, 1, 3, "sat err5");
    s_step(0, 0, 1, 0, 3, "sat idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
